rect_motion_ctl: RTL and testbench
==================================

Name: rect_motion_ctl

Overview:
Parametrised successor to the single-rectangle drop controller. While in FOLLOW, the rectangle tracks the mouse, clamped to the visible area. A rising edge of mouse_left drops it under fixed-point gravity, and it bounces on the floor with halved speed until it comes to rest. Sits between the mouse decoder and the rectangle draw stage; xpos/ypos feed the draw stage directly.

Parameters:
H_ACTIVE, 800, visible width in pixels
V_ACTIVE, 600, visible height in pixels
RECT_W, 48, rectangle width in pixels
RECT_H, 64, rectangle height in pixels
TICK_DIV, 65000, clk cycles per physics tick (>=1)
FRAC, 8, fractional bits of position/velocity
VEL_W, 20, signed velocity width
ACCEL, 2, velocity increment per tick (units 2^-FRAC px/tick)
REST_VEL, 16, bounce speed below which the block settles (2^-FRAC px/tick)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mouse_left  in  1  left button level
mouse_x_position  in  12  mouse x in pixels
mouse_y_position  in  12  mouse y in pixels
xpos  out  12  rectangle top-left x
ypos  out  12  rectangle top-left y
falling  out  1  high in FALL
resting  out  1  high in REST
bounce  out  1  one-cycle pulse on each floor impact

Behaviour:
- Reset: clk and rst as named above; rst is asynchronous and active-high (fixed). Values during/after rst:
  - state=FOLLOW, xpos=0, ypos=0, vel=0, y_fp=0, tick counter=0;
  - falling=0, resting=0, bounce=0;
  - left_q=0 (previous button level).
  - Reset mid-fall aborts immediately.
- Derived values: FLOOR = V_ACTIVE-RECT_H, XMAX = H_ACTIVE-RECT_W.
- Button edge: press = mouse_left & ~left_q; left_q is registered every cycle. A held button never retriggers.
- FOLLOW state:
  - Each cycle: xpos <= min(mouse_x_position, XMAX), ypos <= min(mouse_y_position, FLOOR). Latency is 1 cycle.
  - On press: go to FALL. xpos/ypos hold their current registered values (the mouse sample of the press cycle is ignored). Set y_fp <= ypos<<FRAC, vel <= 0, tick counter <= 0.
- FALL state:
  - xpos frozen.
  - Tick counter counts 0..TICK_DIV-1 and wraps; a tick fires in the cycle the counter equals TICK_DIV-1.
  - On tick, compute s = y_fp + vel (signed, width 12+FRAC+1):
    - If s > FLOOR<<FRAC: y_fp <= FLOOR<<FRAC, vel <= -(vel >>> 1) (arithmetic shift of the pre-tick vel), bounce=1 for that cycle.
      - If |new vel| < REST_VEL: go to REST and vel <= 0.
    - Else if s < 0: y_fp <= 0, vel <= 0.
    - Else: y_fp <= s, vel <= vel + ACCEL, saturating at +(2^(VEL_W-1)-1).
  - ypos = y_fp >> FRAC, registered together with y_fp, so ypos updates in the tick cycle +1.
- REST state: xpos and ypos=FLOOR hold; resting=1. Terminal until rst (see Optional Feature).
- Outputs are registered; falling and resting decode state one cycle after the transition.
- Arithmetic: velocity is signed two's complement VEL_W bits; position is unsigned 12+FRAC bits.

Optional Feature:
RECT_CTL_REGRAB_EN
- Defined: a press in FALL or REST returns to FOLLOW next cycle. vel, tick counter and bounce are cleared; xpos/ypos resume tracking one cycle later.
- Undefined: mouse_left is ignored outside FOLLOW; REST is exited only by rst.

Test Plan:
(Params for all: TICK_DIV=2, FRAC=4, ACCEL=16, V_ACTIVE=100, RECT_H=20 (FLOOR=80), H_ACTIVE=200, RECT_W=40 (XMAX=160), REST_VEL=16.)
1. Assert rst mid-fall asynchronously -> all outputs 0, state FOLLOW; mouse (50,30) after release -> xpos=50, ypos=30 one cycle later.
2. Mouse (190,95) in FOLLOW -> xpos=160, ypos=80; mouse held at (10,10) with mouse_left held high for 20 cycles -> exactly one drop, falling=1.
3. Drop at y=0 -> after tick n, ypos = n(n-1)/2. Tick 13 gives ypos=78 with vel=208; tick 14 gives ypos=80, bounce pulse, vel=-104, still FALL.
4. Drop at y=80 -> tick 1: ypos=80, vel=16; tick 2: bounce pulse, vel=-8 -> REST, resting=1; further mouse_left presses are ignored (macro undefined).
5. With RECT_CTL_REGRAB_EN: press during FALL -> FOLLOW next cycle, falling=0, ypos tracks the mouse 1 cycle later; press in REST -> same.
6. Drop, then mouse moves -> xpos constant throughout FALL/REST; ypos changes only in cycles after ticks (every 2 cycles).

Source files
------------

// File: rtl/rect_motion_ctl.sv
// Rectangle follow/drop/bounce controller feeding the draw stage.
// Optional build macro: RECT_CTL_REGRAB_EN (press in FALL/REST regrabs).
module rect_motion_ctl #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int TICK_DIV = 65000,
  parameter int FRAC     = 8,
  parameter int VEL_W    = 20,
  parameter int ACCEL    = 2,
  parameter int REST_VEL = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x_position,
  input  logic [11:0] mouse_y_position,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling,
  output logic        resting,
  output logic        bounce
);

  localparam int PW = 12 + FRAC;
  localparam int SW = PW + 1;
  localparam int WW = ((SW > VEL_W) ? SW : VEL_W) + 2;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [11:0] FLOOR = 12'(V_ACTIVE - RECT_H);
  localparam logic [11:0] XMAX  = 12'(H_ACTIVE - RECT_W);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic signed [WW-1:0] FLOOR_FP =
    WW'((V_ACTIVE - RECT_H) * (2 ** FRAC));
  localparam logic signed [WW-1:0] ACCEL_W = WW'(ACCEL);
  localparam logic signed [WW-1:0] REST_W  = WW'(REST_VEL);
  localparam logic signed [WW-1:0] VEL_MAX =
    {{(WW-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};

  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    FALL   = 2'd1,
    REST   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [11:0]             xpos_nxt, ypos_nxt;
  logic [11:0]             mx_clamp, my_clamp;
  logic [PW-1:0]           y_fp, y_fp_nxt;
  logic signed [VEL_W-1:0] vel, vel_nxt;
  logic [CW-1:0]           tick_cnt, tick_nxt;
  logic                    left_q, press, tick;
  logic                    bounce_nxt, regrab;

  logic signed [WW-1:0] yfp_w, vel_w, sum;
  logic signed [WW-1:0] half, nvel, nvel_abs, acc;

  assign press = mouse_left & ~left_q;
  assign tick  = (tick_cnt == TICK_LAST);

`ifdef RECT_CTL_REGRAB_EN
  assign regrab = press;
`else
  assign regrab = 1'b0;
`endif

  assign mx_clamp = (mouse_x_position > XMAX) ? XMAX : mouse_x_position;
  assign my_clamp = (mouse_y_position > FLOOR) ? FLOOR : mouse_y_position;

  // Physics is evaluated in a width that holds both position and velocity
  always_comb begin
    yfp_w    = $signed({{(WW-PW){1'b0}}, y_fp});
    vel_w    = $signed({{(WW-VEL_W){vel[VEL_W-1]}}, vel});
    sum      = yfp_w + vel_w;
    half     = vel_w >>> 1;
    nvel     = -half;
    nvel_abs = nvel[WW-1] ? -nvel : nvel;
    acc      = vel_w + ACCEL_W;
    if (acc > VEL_MAX) begin
      acc = VEL_MAX;
    end
  end

  always_comb begin
    state_nxt  = state;
    xpos_nxt   = xpos;
    ypos_nxt   = ypos;
    y_fp_nxt   = y_fp;
    vel_nxt    = vel;
    tick_nxt   = tick_cnt;
    bounce_nxt = 1'b0;
    unique case (state)
      FOLLOW: begin
        xpos_nxt = mx_clamp;
        ypos_nxt = my_clamp;
        if (press) begin
          state_nxt = FALL;
          xpos_nxt  = xpos;
          ypos_nxt  = ypos;
          y_fp_nxt  = {ypos, {FRAC{1'b0}}};
          vel_nxt   = '0;
          tick_nxt  = '0;
        end
      end
      FALL: begin
        if (regrab) begin
          state_nxt = FOLLOW;
          vel_nxt   = '0;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick ? '0 : tick_cnt + CW'(1);
          if (tick) begin
            if (sum > FLOOR_FP) begin
              y_fp_nxt   = FLOOR_FP[PW-1:0];
              vel_nxt    = $signed(nvel[VEL_W-1:0]);
              bounce_nxt = 1'b1;
              if (nvel_abs < REST_W) begin
                state_nxt = REST;
                vel_nxt   = '0;
              end
            end else if (sum < 0) begin
              y_fp_nxt = '0;
              vel_nxt  = '0;
            end else begin
              y_fp_nxt = sum[PW-1:0];
              vel_nxt  = $signed(acc[VEL_W-1:0]);
            end
            ypos_nxt = y_fp_nxt[PW-1:FRAC];
          end
        end
      end
      REST: begin
        if (regrab) begin
          state_nxt = FOLLOW;
          vel_nxt   = '0;
          tick_nxt  = '0;
        end
      end
      default: begin
        state_nxt = FOLLOW;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FOLLOW;
      xpos     <= '0;
      ypos     <= '0;
      y_fp     <= '0;
      vel      <= '0;
      tick_cnt <= '0;
      left_q   <= 1'b0;
      falling  <= 1'b0;
      resting  <= 1'b0;
      bounce   <= 1'b0;
    end else begin
      state    <= state_nxt;
      xpos     <= xpos_nxt;
      ypos     <= ypos_nxt;
      y_fp     <= y_fp_nxt;
      vel      <= vel_nxt;
      tick_cnt <= tick_nxt;
      left_q   <= mouse_left;
      falling  <= (state == FALL);
      resting  <= (state == REST);
      bounce   <= bounce_nxt;
    end
  end

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Directed bench for rect_motion_ctl with small test-plan parameters.
// Regrab steps are enabled when RECT_CTL_REGRAB_EN is defined.
module tb_rect_motion_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_x_position = '0;
  logic [11:0] mouse_y_position = '0;
  logic [11:0] xpos, ypos;
  logic        falling, resting, bounce;

  int n_chk  = 0;
  int n_pass = 0;

  rect_motion_ctl #(
    .H_ACTIVE(200),
    .V_ACTIVE(100),
    .RECT_W  (40),
    .RECT_H  (20),
    .TICK_DIV(2),
    .FRAC    (4),
    .VEL_W   (20),
    .ACCEL   (16),
    .REST_VEL(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mouse_left      (mouse_left),
    .mouse_x_position(mouse_x_position),
    .mouse_y_position(mouse_y_position),
    .xpos            (xpos),
    .ypos            (ypos),
    .falling         (falling),
    .resting         (resting),
    .bounce          (bounce)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic mouse(input int x, input int y);
    mouse_x_position = 12'(x);
    mouse_y_position = 12'(y);
  endtask

  task automatic click();
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    step(1);
    chk("rst_xpos", int'(xpos), 0);
    chk("rst_ypos", int'(ypos), 0);
    chk("rst_falling", int'(falling), 0);
    chk("rst_bounce", int'(bounce), 0);
    rst = 1'b0;

    // drop from y=0: ypos = n(n-1)/2 after tick n
    mouse(10, 0);
    step(1);
    chk("follow_x", int'(xpos), 10);
    chk("follow_y", int'(ypos), 0);
    click();
    mouse(120, 50);
    step(24);
    chk("tick12_y", int'(ypos), 66);
    chk("fall_x_frozen", int'(xpos), 10);
    chk("falling", int'(falling), 1);
    step(1);
    chk("between_ticks_y", int'(ypos), 66);
    step(1);
    chk("tick13_y", int'(ypos), 78);
    chk("tick13_nobounce", int'(bounce), 0);
    step(2);
    chk("tick14_y", int'(ypos), 80);
    chk("tick14_bounce", int'(bounce), 1);
    step(1);
    chk("bounce_pulse_end", int'(bounce), 0);
    chk("still_falling", int'(falling), 1);
    chk("still_not_rest", int'(resting), 0);
    step(1);
    chk("tick15_y", int'(ypos), 73);
    step(2);
    chk("tick16_y", int'(ypos), 68);
    chk("fall_x_still", int'(xpos), 10);

    // asynchronous reset mid-fall
    #3 rst = 1'b1;
    #1;
    chk("async_rst_x", int'(xpos), 0);
    chk("async_rst_y", int'(ypos), 0);
    chk("async_rst_falling", int'(falling), 0);
    step(1);
    rst = 1'b0;
    mouse(50, 30);
    step(1);
    chk("post_rst_x", int'(xpos), 50);
    chk("post_rst_y", int'(ypos), 30);
    chk("post_rst_falling", int'(falling), 0);

    // clamping and boundary values
    mouse(190, 95);
    step(1);
    chk("clamp_x", int'(xpos), 160);
    chk("clamp_y", int'(ypos), 80);
    mouse(160, 80);
    step(1);
    chk("edge_x", int'(xpos), 160);
    chk("edge_y", int'(ypos), 80);

    // held button: one drop, 9 ticks in 20 cycles from y=10
    mouse(10, 10);
    step(1);
    mouse_left = 1'b1;
    step(20);
    chk("held_falling", int'(falling), 1);
    chk("held_x", int'(xpos), 10);
    chk("held_y", int'(ypos), 46);
    mouse_left = 1'b0;

    // drop at floor: settles to REST on second tick
    do_reset();
    mouse(100, 95);
    step(1);
    chk("floor_y", int'(ypos), 80);
    click();
    step(2);
    chk("floor_tick1_y", int'(ypos), 80);
    chk("floor_tick1_nobounce", int'(bounce), 0);
    step(2);
    chk("floor_tick2_bounce", int'(bounce), 1);
    chk("floor_tick2_y", int'(ypos), 80);
    step(1);
    chk("rest_resting", int'(resting), 1);
    chk("rest_falling", int'(falling), 0);
    chk("rest_bounce_end", int'(bounce), 0);
    mouse(5, 5);
    click();
    step(2);
`ifdef RECT_CTL_REGRAB_EN
    chk("rest_press_x", int'(xpos), 5);
    chk("rest_press_y", int'(ypos), 5);
    chk("rest_press_resting", int'(resting), 0);

    // regrab during FALL
    mouse(20, 20);
    step(1);
    click();
    step(4);
    chk("regrab_pre_y", int'(ypos), 21);
    mouse(30, 40);
    click();
    chk("regrab_hold_x", int'(xpos), 20);
    chk("regrab_hold_y", int'(ypos), 21);
    step(1);
    chk("regrab_x", int'(xpos), 30);
    chk("regrab_y", int'(ypos), 40);
    chk("regrab_falling", int'(falling), 0);
`else
    chk("rest_press_x", int'(xpos), 100);
    chk("rest_press_y", int'(ypos), 80);
    chk("rest_press_resting", int'(resting), 1);
    step(4);
    chk("rest_hold_resting", int'(resting), 1);
    chk("rest_hold_x", int'(xpos), 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
